// File: rtl/chocorrol_seq.sv
// chocorrol_seq: instruction sequencer for the chocorrol register-file /
// ALU / result-memory datapath.
//
// Instruction words come in over a valid/ready handshake and are buffered
// in a small FIFO. Each one is issued to the datapath as READ, EXEC, WRITE.
// Both write enables belong to this block: op_we is tied low and res_we is
// asserted only in WRITE.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   instr_valid  upstream instruction present
//   instr_in     [17:13] rs, [12:10] sel, [9:5] rt, [4:0] rd; [19:18] ignored
//   instr_ready  FIFO can accept (registered, equals !full)
//   ctrl_word    {op_we, res_we, rs, sel, rt, rd} to the datapath
//   zflow        ALU zero flag, sampled in EXEC only
//   busy         FSM is not in IDLE
//   done         one-cycle pulse the cycle after WRITE
//   zero_last    zflow captured in EXEC of the last retired instruction
//   retired      count of completed WRITE phases (wraps)
//
// Optional build macro CHOCORROL_SKIP_ON_ZERO_EN: when the retiring
// instruction saw zflow=1, the following instruction is dropped.
//
// state  | meaning
// IDLE   | waiting for a FIFO entry; ctrl_word = 0
// READ   | operands addressed from ir
// EXEC   | ALU evaluates; zflow captured
// WRITE  | res_we asserted; retire and pop next if available
module chocorrol_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [19:0]      instr_in,
  output logic             instr_ready,
  output logic [19:0]      ctrl_word,
  input  logic             zflow,
  output logic             busy,
  output logic             done,
  output logic             zero_last,
  output logic [CNT_W-1:0] retired
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  logic [17:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q, cnt_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  state_t           state_q, state_d;
  logic [17:0]      ir_q;
  logic             ir_load;
  logic             zf_q;
  logic             done_q;
  logic             zero_last_q;
  logic [CNT_W-1:0] retired_q;
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
  logic             skip_q, skip_d;
`endif

  // Opcode-extension bits are not used by this datapath.
  logic unused_hi_bits;
  assign unused_hi_bits = ^instr_in[19:18];

  assign fifo_full   = (cnt_q == DEPTH_C);
  assign fifo_empty  = (cnt_q == '0);
  assign instr_ready = !fifo_full;
  assign push        = instr_valid && !fifo_full;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= instr_in[17:0];
  end

  // Pops only ever come from the FSM, which checks fifo_empty, and the
  // popped entry is read from storage, so a push into an empty FIFO is
  // not visible until the following cycle.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ir_load = 1'b0;
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
    skip_d  = skip_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
          if (skip_q) begin
            skip_d = 1'b0;
          end else begin
            ir_load = 1'b1;
            state_d = S_READ;
          end
`else
          ir_load = 1'b1;
          state_d = S_READ;
`endif
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_IDLE;
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
        if (zf_q) begin
          if (!fifo_empty) pop = 1'b1;
          else             skip_d = 1'b1;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          ir_load = 1'b1;
          state_d = S_READ;
        end
`else
        if (!fifo_empty) begin
          pop     = 1'b1;
          ir_load = 1'b1;
          state_d = S_READ;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      ir_q        <= '0;
      zf_q        <= 1'b0;
      done_q      <= 1'b0;
      zero_last_q <= 1'b0;
      retired_q   <= '0;
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
      skip_q      <= 1'b0;
`endif
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      if (ir_load) ir_q <= mem_q[rd_ptr_q];
      if (state_q == S_EXEC) zf_q <= zflow;
      done_q <= (state_q == S_WRITE);
      if (state_q == S_WRITE) begin
        retired_q   <= retired_q + CNT_W'(1);
        zero_last_q <= zf_q;
      end
`ifdef CHOCORROL_SKIP_ON_ZERO_EN
      skip_q <= skip_d;
`endif
    end
  end

  // Decoded from registered state and ir only; op_we is never driven high.
  always_comb begin
    ctrl_word = '0;
    case (state_q)
      S_READ, S_EXEC: ctrl_word = {2'b00, ir_q};
      S_WRITE:        ctrl_word = {2'b01, ir_q};
      default:        ctrl_word = '0;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign zero_last = zero_last_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_chocorrol_seq.sv
module tb_chocorrol_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [19:0] instr_in;
  logic        instr_ready;
  logic [19:0] ctrl_word;
  logic        zflow;
  logic        busy;
  logic        done;
  logic        zero_last;
  logic [15:0] retired;

  chocorrol_seq #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_in    (instr_in),
    .instr_ready (instr_ready),
    .ctrl_word   (ctrl_word),
    .zflow       (zflow),
    .busy        (busy),
    .done        (done),
    .zero_last   (zero_last),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int op_we_seen = 0;
  int t0;

  logic [17:0] wq[$];
  int          wc[$];
  int          dc[$];
  logic        rdy_hist [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ctrl_word[18]) begin
      wq.push_back(ctrl_word[17:0]);
      wc.push_back(cyc);
    end
    if (ctrl_word[19]) op_we_seen <= op_we_seen + 1;
    if (done) dc.push_back(cyc);
    if (cyc < 4096) rdy_hist[cyc] <= instr_ready;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [19:0] w);
    instr_valid = 1'b1;
    instr_in    = w;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wq.size() < n && k < budget) begin
      tick();
      k++;
    end
    if (wq.size() < n) chk("write_timeout", wq.size(), n);
    // let the trailing done pulse land
    tick();
    tick();
  endtask

  logic [17:0] bb [4]   = '{18'h11111, 18'h22222, 18'h03333, 18'h14444};
  logic [17:0] fw [6]   = '{18'h0A001, 18'h0A002, 18'h0A003, 18'h0A004, 18'h0A005, 18'h0A006};
  logic [17:0] mr [4]   = '{18'h01001, 18'h02002, 18'h03003, 18'h04004};

  initial begin
    int idx;
    int guard;
    logic rb;

    // reset with valid held high: nothing may be accepted
    rst = 1'b1; instr_valid = 1'b1; instr_in = 20'hFFFFF; zflow = 1'b0;
    tick();
    chk("rst_ready", instr_ready, 1);
    tick();
    chk("rst_ctrl", ctrl_word, 0);
    chk("rst_retired", retired, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_zero_last", zero_last, 0);
    rst = 1'b0; instr_valid = 1'b0;
    tick();
    tick();
    chk("rst_noaccept_busy", busy, 0);
    chk("rst_noaccept_writes", wq.size(), 0);

    // single instruction timing
    wq.delete(); wc.delete(); dc.delete();
    push1(20'h068A7);
    t0 = cyc;
    chk("single_idle_busy", busy, 0);
    tick();
    chk("single_read", ctrl_word, 20'h068A7);
    chk("single_busy", busy, 1);
    tick();
    chk("single_exec", ctrl_word, 20'h068A7);
    tick();
    chk("single_write", ctrl_word, 20'h468A7);
    chk("single_done_early", done, 0);
    tick();
    chk("single_done", done, 1);
    chk("single_retired", retired, 1);
    chk("single_ctrl_idle", ctrl_word, 0);
    chk("single_zero_last", zero_last, 0);
    tick();
    chk("single_done_once", done, 0);

    // upper bits ignored; zflow held high gives zero_last=1
    wq.delete();
    zflow = 1'b1;
    push1(20'hC1234);
    tick();
    chk("hibits_read", ctrl_word, 20'h01234);
    wait_writes(1, 10);
    zflow = 1'b0;
    chk("zl_set", zero_last, 1);
    chk("zl_retired", retired, 2);

    // zflow high except during EXEC: only the EXEC sample counts
    zflow = 1'b1;
    push1(20'h00055);
    tick();           // READ
    tick();           // EXEC
    zflow = 1'b0;
    tick();           // WRITE
    zflow = 1'b1;
    tick();
    zflow = 1'b0;
    chk("zl_exec_only", zero_last, 0);
    chk("zl2_retired", retired, 3);

    // back-to-back: four pushes, writes 3 cycles apart
    wq.delete(); wc.delete();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bb_ready%0d", i), instr_ready, 1);
      push1({2'b00, bb[i]});
      if (i == 0) t0 = cyc;
    end
    wait_writes(4, 40);
    for (int i = 0; i < 4; i++) begin
      if (i < wq.size()) begin
        chk($sformatf("bb_word%0d", i), wq[i], bb[i]);
        chk($sformatf("bb_cyc%0d", i), wc[i], t0 + 3 + 3 * i);
      end
    end
    chk("bb_retired", retired, 7);

    // full FIFO: valid held across six words
    wq.delete(); wc.delete();
    idx = 0; guard = 0;
    while (idx < 6 && guard < 40) begin
      instr_valid = 1'b1;
      instr_in    = {2'b00, fw[idx]};
      rb = instr_ready;
      tick();
      if (idx == 0 && rb) t0 = cyc;
      if (rb) idx++;
      guard++;
    end
    instr_valid = 1'b0;
    if (idx < 6) chk("full_push_timeout", idx, 6);
    tick(); tick(); tick();
    chk("full_rdy_before", rdy_hist[t0 + 4], 1);
    chk("full_rdy_drop", rdy_hist[t0 + 5], 0);
    chk("full_rdy_hold", rdy_hist[t0 + 6], 0);
    chk("full_rdy_back", rdy_hist[t0 + 7], 1);
    wait_writes(6, 60);
    chk("full_count", wq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < wq.size()) chk($sformatf("full_word%0d", i), wq[i], fw[i]);
    end
    chk("full_retired", retired, 13);

    // reset during EXEC of the second of three queued instructions
    wq.delete(); wc.delete();
    for (int i = 0; i < 3; i++) begin
      push1({2'b00, mr[i]});
      if (i == 0) t0 = cyc;
    end
    while (cyc < t0 + 5) tick();
    chk("mr_in_exec", ctrl_word, {2'b00, mr[1]});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("mr_writes", wq.size(), 1);
    if (wq.size() > 0) chk("mr_first_word", wq[0], mr[0]);
    chk("mr_retired", retired, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ready", instr_ready, 1);
    push1({2'b00, mr[3]});
    wait_writes(2, 10);
    if (wq.size() > 1) chk("mr_next_word", wq[1], mr[3]);
    chk("mr_next_retired", retired, 1);

`ifdef CHOCORROL_SKIP_ON_ZERO_EN
    // A retires with zflow=1, so B is dropped and C retires
    wq.delete();
    push1(20'h0AAAA);
    push1(20'h0BBBB);
    push1(20'h0CCCC);
    zflow = 1'b1;     // A is in EXEC this cycle
    tick();
    zflow = 1'b0;
    wait_writes(2, 20);
    repeat (4) tick();
    chk("skip_writes", wq.size(), 2);
    if (wq.size() > 1) chk("skip_c_word", wq[1], 18'h0CCCC);
    chk("skip_retired", retired, 3);
    chk("skip_zero_last", zero_last, 0);
    chk("done_count", dc.size(), 17);
`else
    chk("done_count", dc.size(), 15);
`endif
    chk("op_we_never", op_we_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
